load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage controller that sits directly upstream of the byte-addressed, big-endian data memory (128 bytes; word at A = {mem[A], mem[A+1]}).
- Accepts load/store requests from the CPU execute stage over a valid/ready handshake and computes the effective address.
- Range-checks the address, drives the data-memory ports, and returns a registered response.
- Byte stores use read-modify-write, because the memory always writes two bytes.

Parameters:
- MEM_BYTES, 128: data-memory size in bytes, used for range checks.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  unit can accept a request this cycle.
- Op  input  3  000 LW, 001 LB (sign-extend), 010 LBU (zero-extend), 100 SW, 101 SB; all others are illegal.
- Base  input  16  base register value.
- Offset  input  16  signed offset.
- StoreData  input  16  store data; SB uses [7:0].
- RespValid  output  1  response present.
- RespReady  input  1  consumer accepts the response.
- RespData  output  16  load result; 0 for stores and faults.
- Fault  output  1  qualifies RespValid: out-of-range or illegal op.
- MemAdresa  output  16  to data-memory address.
- MemWriteData  output  16  to data-memory write data.
- MemWrite  output  1  to data-memory write enable.
- MemRead  output  1  to data-memory read enable.
- MemReadData  input  16  from data memory (combinational read).

Behaviour:
- States: IDLE, ACCESS, RMW_WR, RESP.
- Reset (asynchronous, immediate, independent of Clock):
  - State goes to IDLE; all registers clear.
  - ReqReady=1, RespValid=0, RespData=0, Fault=0, MemWrite=0, MemRead=0, MemAdresa=0, MemWriteData=0.
  - Reset mid-operation abandons the access. MemWrite drops asynchronously, so no write occurs on an edge where Reset is high.
- Memory-side outputs: driven from registered state/address only. They are 0 in IDLE and RESP.
- ReqReady: 1 only in IDLE.
- Accept: ReqValid & ReqReady at a rising edge latches Op, StoreData, and EA.
  - EA = Base + Offset, modulo 2^16. No saturation; a wrap to a large value faults.
- Fault check at accept:
  - LB/LBU require EA <= MEM_BYTES-1.
  - LW/SW/SB require EA <= MEM_BYTES-2.
  - Illegal Op always faults.
  - A faulting request goes straight to RESP with Fault=1, RespData=0. There is no memory cycle and MemRead/MemWrite stay 0.
- Non-faulting request goes to ACCESS for 1 cycle, with MemAdresa=EA:
  - LW: MemRead=1; RespData <= MemReadData.
  - LB: MemRead=1; RespData <= sign-extend(MemReadData[15:8]).
  - LBU: MemRead=1; RespData <= {8'h00, MemReadData[15:8]}.
  - SW: MemWrite=1, MemWriteData=StoreData. Memory commits at the end of this cycle.
  - SB: MemRead=1; latch low byte L = MemReadData[7:0]; next state is RMW_WR.
- ACCESS transitions: LW/LB/LBU/SW go to RESP; SB goes to RMW_WR.
- RMW_WR (SB only), 1 cycle:
  - MemAdresa=EA, MemWrite=1, MemWriteData={StoreData[7:0], L}.
  - mem[EA+1] is rewritten with its own value, so it is unchanged.
  - Next state is RESP.
- RESP:
  - RespValid=1; RespData/Fault held stable while RespReady=0.
  - Transfer completes at an edge with RespReady=1; state goes to IDLE, RespValid drops next cycle.
  - No new request is accepted in RESP; single outstanding request.
- Latency, accept edge to first RespValid cycle:
  - Fault: 1 cycle.
  - LW/LB/LBU/SW: 2 cycles.
  - SB: 3 cycles.
- Throughput: one request per (latency + 1) cycles with RespReady held at 1.
- ReqValid while ReqReady=0 is ignored; the requester must hold it.

Test Plan:
- Reset then LW: preload mem[10]=8'hAB, mem[11]=8'hCD; Op=000, Base=8, Offset=2 -> MemRead=1 with MemAdresa=10 one cycle after accept; RespValid with RespData=16'hABCD, Fault=0, 2 cycles after accept.
- LB/LBU sign handling: mem[20]=8'h9C; LB EA=20 -> RespData=16'hFF9C. LBU EA=20 -> 16'h009C. LB EA=127 -> no fault, RespData=sign-extend(mem[127]).
- SB read-modify-write: mem[30]=8'h11, mem[31]=8'h22; SB EA=30, StoreData=16'h55AA -> one read cycle, then MemWrite with MemWriteData=16'hAA22; afterwards mem[30]=8'hAA, mem[31]=8'h22; response Fault=0 3 cycles after accept.
- Range/illegal faults:
  - SW EA=127 -> Fault=1 after 1 cycle, MemWrite never asserted.
  - LW with Base=16'hFFFF, Offset=16'h0002 (EA=1) -> normal.
  - LW with Base=0, Offset=16'hFFFF -> Fault=1.
  - Op=011 -> Fault=1, RespData=0.
- Backpressure: LW with RespReady=0 for 5 cycles -> RespValid and RespData stable, ReqReady=0, a second ReqValid is ignored; RespReady=1 -> IDLE, then the second request is accepted.
- Reset mid-operation: assert Reset asynchronously during RMW_WR of SB EA=40 (mem[40]=8'h01) -> MemWrite falls immediately, mem[40] stays 8'h01, outputs return to reset values, ReqReady=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller in front of a 16-bit, big-endian, byte-addressed data memory.
// One request outstanding at a time; byte stores are done as read-modify-write.
module load_store_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [2:0]  Op,
    input  logic [15:0] Base,
    input  logic [15:0] Offset,
    input  logic [15:0] StoreData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [15:0] RespData,
    output logic        Fault,
    output logic [15:0] MemAdresa,
    output logic [15:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [15:0] MemReadData,
    output logic [1:0]  DbgState
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // once raised, valid and its payload stay stable until that edge.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;

    localparam logic [15:0] LIM_BYTE = 16'(MEM_BYTES - 1);
    localparam logic [15:0] LIM_WORD = 16'(MEM_BYTES - 2);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] ea_q, ea_d;
    logic [15:0] sdata_q, sdata_d;
    logic [7:0]  low_q, low_d;
    logic [15:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [15:0] req_ea;
    logic        req_legal;
    logic        req_byte;
    logic        req_fault;

    assign req_ea    = Base + Offset;
    assign req_legal = (Op == OP_LW) || (Op == OP_LB) || (Op == OP_LBU) ||
                       (Op == OP_SW) || (Op == OP_SB);
    assign req_byte  = (Op == OP_LB) || (Op == OP_LBU);
    assign req_fault = !req_legal || (req_byte ? (req_ea > LIM_BYTE) : (req_ea > LIM_WORD));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            op_q    <= 3'b000;
            ea_q    <= 16'h0000;
            sdata_q <= 16'h0000;
            low_q   <= 8'h00;
            rdata_q <= 16'h0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ea_q    <= ea_d;
            sdata_q <= sdata_d;
            low_q   <= low_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ea_d    = ea_q;
        sdata_d = sdata_q;
        low_d   = low_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    op_d    = Op;
                    ea_d    = req_ea;
                    sdata_d = StoreData;
                    low_d   = 8'h00;
                    rdata_d = 16'h0000;
                    fault_d = req_fault;
                    state_d = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                case (op_q)
                    OP_LW:   rdata_d = MemReadData;
                    OP_LB:   rdata_d = {{8{MemReadData[15]}}, MemReadData[15:8]};
                    OP_LBU:  rdata_d = {8'h00, MemReadData[15:8]};
                    // The neighbour byte is captured so the two-byte write leaves it intact.
                    OP_SB:   low_d   = MemReadData[7:0];
                    default: rdata_d = 16'h0000;
                endcase
                state_d = (op_q == OP_SB) ? RMW_WR : RESP;
            end
            RMW_WR: state_d = RESP;
            RESP: begin
                if (RespReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes decode from registered state only, so Reset removes them immediately.
    always_comb begin
        MemAdresa    = 16'h0000;
        MemWriteData = 16'h0000;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        case (state_q)
            ACCESS: begin
                MemAdresa = ea_q;
                if (op_q == OP_SW) begin
                    MemWrite     = 1'b1;
                    MemWriteData = sdata_q;
                end else begin
                    MemRead = 1'b1;
                end
            end
            RMW_WR: begin
                MemAdresa    = ea_q;
                MemWrite     = 1'b1;
                MemWriteData = {sdata_q[7:0], low_q};
            end
            default: ;
        endcase
    end

    assign ReqReady  = (state_q == IDLE);
    assign RespValid = (state_q == RESP);
    assign RespData  = rdata_q;
    assign Fault     = fault_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural 128-byte big-endian memory,
// reference model computing expected responses into a scoreboard queue.
module tb_load_store_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  Op;
    logic [15:0] Base;
    logic [15:0] Offset;
    logic [15:0] StoreData;
    logic        RespValid;
    logic        RespReady;
    logic [15:0] RespData;
    logic        Fault;
    logic [15:0] MemAdresa;
    logic [15:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] MemReadData;
    logic [1:0]  DbgState;

    logic [7:0]  mem [0:127];
    logic [16:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;

    load_store_unit #(.MEM_BYTES(128)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Op(Op), .Base(Base), .Offset(Offset), .StoreData(StoreData),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespData(RespData), .Fault(Fault),
        .MemAdresa(MemAdresa), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData),
        .DbgState(DbgState)
    );

    // clock / memory model
    always #5 Clock = ~Clock;

    assign MemReadData = {mem[MemAdresa[6:0]], mem[7'(MemAdresa[6:0] + 7'd1)]};

    always @(posedge Clock) begin
        if (MemWrite) begin
            mem[MemAdresa[6:0]]               = MemWriteData[15:8];
            mem[7'(MemAdresa[6:0] + 7'd1)]    = MemWriteData[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one request, expectations from the reference model, optional response backpressure
    task automatic do_req(input logic [2:0] op, input logic [15:0] base, input logic [15:0] off,
                          input logic [15:0] sd, input int hold);
        logic [15:0] ea;
        logic [6:0]  a;
        logic        legal, flt, exp_r, exp_w, saw_r, saw_w, tmo;
        logic [15:0] ed, exp_wd, wd, addr, snap;
        logic [16:0] exp;
        int          elat, lat;
        ea    = base + off;
        a     = ea[6:0];
        legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
        flt   = !legal || (ea > (((op == 3'd1) || (op == 3'd2)) ? 16'd127 : 16'd126));
        ed    = 16'h0000;
        if (!flt) begin
            case (op)
                3'd0: ed = {mem[a], mem[7'(a + 7'd1)]};
                3'd1: ed = {{8{mem[a][7]}}, mem[a]};
                3'd2: ed = {8'h00, mem[a]};
                default: ed = 16'h0000;
            endcase
        end
        elat   = flt ? 1 : ((op == 3'd5) ? 3 : 2);
        exp_r  = !flt && (op != 3'd4);
        exp_w  = !flt && ((op == 3'd4) || (op == 3'd5));
        exp_wd = (op == 3'd4) ? sd : {sd[7:0], mem[7'(a + 7'd1)]};
        exp_q.push_back({flt, ed});

        @(negedge Clock);
        check("req_ready_idle", ReqReady, 1);
        Op = op; Base = base; Offset = off; StoreData = sd;
        ReqValid  = 1'b1;
        RespReady = (hold == 0);
        @(posedge Clock);
        #1 ReqValid = 1'b0;

        lat = 1; saw_r = 0; saw_w = 0; wd = 0; addr = 0; tmo = 0;
        forever begin
            @(negedge Clock);
            if (RespValid) break;
            if (MemRead) saw_r = 1;
            if (MemWrite) begin saw_w = 1; wd = MemWriteData; end
            if (lat == 1) addr = MemAdresa;
            if (lat > 8) begin tmo = 1; break; end
            @(posedge Clock);
            lat++;
        end
        check("resp_timeout", tmo, 0);
        check("latency", lat, elat);
        check("mem_read_seen", saw_r, exp_r);
        check("mem_write_seen", saw_w, exp_w);
        if (exp_w) check("mem_wdata", wd, exp_wd);
        if (!flt) check("mem_addr", addr, ea);

        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("resp_data", RespData, exp[15:0]);
            check("resp_fault", Fault, exp[16]);
        end else begin
            check("scoreboard_empty", 1, 0);
        end

        if (hold > 0) begin
            snap = RespData;
            for (int i = 0; i < hold; i++) begin
                Op = 3'd0; Base = 16'd2; Offset = 16'd0;
                ReqValid = 1'b1;
                @(posedge Clock);
                @(negedge Clock);
                check("bp_valid", RespValid, 1);
                check("bp_data", RespData, snap);
                check("bp_req_ready", ReqReady, 0);
            end
            ReqValid  = 1'b0;
            RespReady = 1'b1;
        end
        @(posedge Clock);
        @(negedge Clock);
        check("resp_drop", RespValid, 0);
        check("back_idle", ReqReady, 1);
    endtask

    initial begin
        logic [2:0] ops [8];
        ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom_range(0, 255));
        ReqValid = 0; Op = 0; Base = 0; Offset = 0; StoreData = 0; RespReady = 1;
        Reset = 1'b1;
        #1;
        check("rst_req_ready", ReqReady, 1);
        check("rst_resp_valid", RespValid, 0);
        check("rst_resp_data", RespData, 0);
        check("rst_fault", Fault, 0);
        check("rst_mem_strobes", {MemWrite, MemRead}, 0);
        check("rst_mem_addr", MemAdresa, 0);
        check("rst_mem_wdata", MemWriteData, 0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;

        mem[10] = 8'hAB; mem[11] = 8'hCD;
        do_req(3'd0, 16'd8, 16'd2, 16'h0, 0);
        mem[20] = 8'h9C;
        do_req(3'd1, 16'd20, 16'd0, 16'h0, 0);
        do_req(3'd2, 16'd18, 16'd2, 16'h0, 0);
        do_req(3'd1, 16'd100, 16'd27, 16'h0, 0);
        mem[30] = 8'h11; mem[31] = 8'h22;
        do_req(3'd5, 16'd30, 16'd0, 16'h55AA, 0);
        check("sb_byte_written", mem[30], 8'hAA);
        check("sb_neighbour_kept", mem[31], 8'h22);
        do_req(3'd4, 16'd127, 16'd0, 16'h1234, 0);
        do_req(3'd0, 16'hFFFF, 16'h0002, 16'h0, 0);
        do_req(3'd0, 16'h0000, 16'hFFFF, 16'h0, 0);
        do_req(3'd3, 16'd4, 16'd0, 16'h0, 0);
        do_req(3'd4, 16'd50, 16'd0, 16'hBEEF, 0);
        check("sw_hi", mem[50], 8'hBE);
        check("sw_lo", mem[51], 8'hEF);
        do_req(3'd0, 16'd50, 16'd0, 16'h0, 5);
        do_req(3'd0, 16'd2, 16'd0, 16'h0, 0);

        for (int n = 0; n < 24; n++)
            do_req(ops[$urandom_range(0, 7)], 16'($urandom_range(0, 140)),
                   16'($urandom_range(0, 2)), 16'($urandom_range(0, 65535)), $urandom_range(0, 2));

        // reset while the SB write-back cycle is on the memory port
        mem[40] = 8'h01;
        @(negedge Clock);
        Op = 3'd5; Base = 16'd40; Offset = 16'd0; StoreData = 16'h77FF;
        ReqValid = 1'b1; RespReady = 1'b1;
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check("rmw_write_active", MemWrite, 1);
        #2 Reset = 1'b1;
        #1;
        check("rst_async_write_drop", MemWrite, 0);
        check("rst_async_valid", RespValid, 0);
        check("rst_async_addr", MemAdresa, 0);
        check("rst_async_ready", ReqReady, 1);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("rst_mem_untouched", mem[40], 8'h01);
        check("rst_release_ready", ReqReady, 1);
        do_req(3'd1, 16'd40, 16'd0, 16'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
